// File: rtl/qpsk_rx_timing.sv
// qpsk_rx_timing: receive-side QPSK bit timing.
// Counts MSF carrier pulses from the one-second boundary and produces the
// mid-bit symbol sample strobe, the bit-boundary strobe, the frame bit count
// and the frame-done strobe for the demodulator / bit slicer.
// Optional feature: define QPSK_RX_RESYNC_EN to realign the carrier counter
// on every one-second rising edge seen while running (reported on
// resync_event). Without the macro, resync_event is tied low.
module qpsk_rx_timing #(
  parameter int BITS_PER_FRAME = 64,
  parameter int BIT_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 msf_carrier_pulse,
  input  logic [12:0]          msf_cp_per_bit,
  input  logic                 one_sec_pulse,
  input  logic                 qpsk_rx_enable,
  output logic [12:0]          msf_carrier_counter,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 symbol_strobe,
  output logic                 bit_end,
  output logic                 rx_active,
  output logic                 frame_done,
  output logic                 resync_event
);

  localparam logic [BIT_CNT_W-1:0] FRAME_BITS = BIT_CNT_W'(BITS_PER_FRAME);
  localparam logic [12:0]          CP_MIN     = 13'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 one_sec_q;
  logic                 sec_edge;
  logic [12:0]          cp_lat_q, cp_lat_d;
  logic [12:0]          cnt_q, cnt_d;
  logic [12:0]          cp_clamped;
  logic [12:0]          cp_last;
  logic [12:0]          half;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_inc;
  logic                 sym_q, sym_d;
  logic                 bend_q, bend_d;
  logic                 fdone_q, fdone_d;
  logic                 active_q;
`ifdef QPSK_RX_RESYNC_EN
  logic                 resync_q, resync_d;
`endif

  // Derived timing values: the one-second rising edge, the clamped bit
  // length to latch on RUN entry, the last counter value of a bit and the
  // mid-bit sample point of the latched bit length.
  always_comb begin
    sec_edge    = one_sec_pulse & ~one_sec_q;
    cp_clamped  = (msf_cp_per_bit < CP_MIN) ? CP_MIN : msf_cp_per_bit;
    cp_last     = cp_lat_q - 13'd1;
    half        = cp_lat_q >> 1;
    bit_cnt_inc = bit_cnt_q + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
  end

  // Delay the one-second marker by a clock so only its rising edge acts.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      one_sec_q <= 1'b0;
    end else begin
      one_sec_q <= one_sec_pulse;
    end
  end

  // Next state, counters and strobe requests; an abort (enable low in RUN)
  // takes priority over everything so no strobe follows it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    cp_lat_d  = cp_lat_q;
    sym_d     = 1'b0;
    bend_d    = 1'b0;
    fdone_d   = 1'b0;
`ifdef QPSK_RX_RESYNC_EN
    resync_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (qpsk_rx_enable) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!qpsk_rx_enable) begin
          state_d = IDLE;
        end else if (sec_edge) begin
          state_d   = RUN;
          cnt_d     = '0;
          bit_cnt_d = '0;
          cp_lat_d  = cp_clamped;
        end
      end
      RUN: begin
        if (!qpsk_rx_enable) begin
          state_d = IDLE;
`ifdef QPSK_RX_RESYNC_EN
        end else if (sec_edge) begin
          cnt_d    = '0;
          resync_d = 1'b1;
`endif
        end else if (msf_carrier_pulse) begin
          if (cnt_q == cp_last) begin
            cnt_d     = '0;
            bit_cnt_d = bit_cnt_inc;
            bend_d    = 1'b1;
            if (bit_cnt_inc == FRAME_BITS) begin
              fdone_d = 1'b1;
              state_d = ARMED;
            end
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
          if (cnt_d == half) begin
            sym_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and strobe registers; rx_active trails the state by one clock.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      cp_lat_q  <= CP_MIN;
      sym_q     <= 1'b0;
      bend_q    <= 1'b0;
      fdone_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cp_lat_q  <= cp_lat_d;
      sym_q     <= sym_d;
      bend_q    <= bend_d;
      fdone_q   <= fdone_d;
      active_q  <= (state_q == RUN);
    end
  end

`ifdef QPSK_RX_RESYNC_EN
  // Realignment strobe register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      resync_q <= 1'b0;
    end else begin
      resync_q <= resync_d;
    end
  end

  assign resync_event = resync_q;
`else
  assign resync_event = 1'b0;
`endif

  assign msf_carrier_counter = cnt_q;
  assign bit_count           = bit_cnt_q;
  assign symbol_strobe       = sym_q;
  assign bit_end             = bend_q;
  assign frame_done          = fdone_q;
  assign rx_active           = active_q;

endmodule

// File: tb/tb_qpsk_rx_timing.sv
// tb_qpsk_rx_timing: self-checking bench for qpsk_rx_timing.
// Strobe expectations are pushed to a scoreboard queue as stimulus is driven
// and popped by a negedge monitor; each test task also checks counters inline.
module tb_qpsk_rx_timing;

  localparam int BITS_PER_FRAME = 64;
  localparam int BIT_CNT_W      = 16;
`ifdef QPSK_RX_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic                 carrierPulse;
  logic [12:0]          cpPerBit;
  logic                 oneSec;
  logic                 rxEnable;
  logic [12:0]          carrierCounter;
  logic [BIT_CNT_W-1:0] bitCount;
  logic                 symbolStrobe;
  logic                 bitEnd;
  logic                 rxActive;
  logic                 frameDone;
  logic                 resyncEvent;

  qpsk_rx_timing #(
    .BITS_PER_FRAME(BITS_PER_FRAME),
    .BIT_CNT_W     (BIT_CNT_W)
  ) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .msf_carrier_pulse  (carrierPulse),
    .msf_cp_per_bit     (cpPerBit),
    .one_sec_pulse      (oneSec),
    .qpsk_rx_enable     (rxEnable),
    .msf_carrier_counter(carrierCounter),
    .bit_count          (bitCount),
    .symbol_strobe      (symbolStrobe),
    .bit_end            (bitEnd),
    .rx_active          (rxActive),
    .frame_done         (frameDone),
    .resync_event       (resyncEvent)
  );

  always #40 clk = ~clk;

  typedef struct {
    int   cyc;
    logic sym;
    logic bend;
    logic fdone;
    logic resync;
  } exp_t;

  typedef enum int {M_IDLE, M_ARMED, M_RUN} mstate_t;

  exp_t    expQ[$];
  int      testsRun    = 0;
  int      testsFailed = 0;
  int      cyc         = 0;
  mstate_t mState      = M_IDLE;
  bit      prevSec     = 1'b0;
  int      mPulses     = 0;
  int      mBits       = 0;
  int      mCp         = 2;

  // Scoreboard monitor: every strobe must match the expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (aresetn === 1'b1) begin
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        testsRun++;
        if ({symbolStrobe, bitEnd, frameDone, resyncEvent} !== {e.sym, e.bend, e.fdone, e.resync}) begin
          testsFailed++;
          $display("[TB] FAIL strobes cycle %0d: got sym/bend/fdone/resync=%b%b%b%b, expected %b%b%b%b",
                   cyc, symbolStrobe, bitEnd, frameDone, resyncEvent, e.sym, e.bend, e.fdone, e.resync);
        end
      end else if ({symbolStrobe, bitEnd, frameDone, resyncEvent} !== 4'b0000) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_strobe cycle %0d: got sym/bend/fdone/resync=%b%b%b%b, expected 0000",
                 cyc, symbolStrobe, bitEnd, frameDone, resyncEvent);
      end
    end
  end

  initial begin
    #(80 * 60000);
    $display("[TB] FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Drive one clock of stimulus and push any strobes the receiver should emit.
  task automatic cycleDrive(input bit p, input bit s, input bit en);
    exp_t e;
    bit   secEdge;
    int   pos;
    carrierPulse = p;
    oneSec       = s;
    rxEnable     = en;
    secEdge      = s && !prevSec;
    prevSec      = s;
    step();
    e.cyc = cyc; e.sym = 1'b0; e.bend = 1'b0; e.fdone = 1'b0; e.resync = 1'b0;
    case (mState)
      M_IDLE:  if (en) mState = M_ARMED;
      M_ARMED: begin
        if (!en) mState = M_IDLE;
        else if (secEdge) begin
          mState  = M_RUN;
          mPulses = 0;
          mBits   = 0;
          mCp     = (cpPerBit < 13'd2) ? 2 : int'(cpPerBit);
        end
      end
      default: begin
        if (!en) mState = M_IDLE;
        else if (RESYNC && secEdge) begin
          mPulses  = 0;
          e.resync = 1'b1;
        end else if (p) begin
          mPulses++;
          pos = mPulses % mCp;
          if (pos == mCp / 2) e.sym = 1'b1;
          if (pos == 0) begin
            e.bend = 1'b1;
            mBits++;
            if (mBits == BITS_PER_FRAME) begin
              e.fdone = 1'b1;
              mState  = M_ARMED;
            end
          end
        end
      end
    endcase
    if (e.sym || e.bend || e.fdone || e.resync) expQ.push_back(e);
  endtask

  task automatic pulses(input int n, input int gap, input bit en);
    for (int i = 0; i < n; i++) begin
      cycleDrive(1'b1, 1'b0, en);
      repeat (gap - 1) cycleDrive(1'b0, 1'b0, en);
    end
  endtask

  task automatic enterRun();
    cycleDrive(1'b0, 1'b0, 1'b1);
    cycleDrive(1'b0, 1'b1, 1'b1);
    cycleDrive(1'b0, 1'b1, 1'b1);
    cycleDrive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic applyReset();
    aresetn = 1'b0; carrierPulse = 1'b0; oneSec = 1'b0; rxEnable = 1'b0;
    mState = M_IDLE; prevSec = 1'b0; mPulses = 0; mBits = 0; mCp = 2;
    expQ.delete();
    repeat (2) step();
    #20 aresetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; carrierPulse = 1'b0; oneSec = 1'b0; rxEnable = 1'b0; cpPerBit = 13'd20;
    mState = M_IDLE; prevSec = 1'b0; mPulses = 0; mBits = 0; mCp = 2;
    expQ.delete();
    step();
    testsRun++; if (carrierCounter !== 13'd0) begin testsFailed++; $display("[TB] FAIL reset_counter: got %0d, expected 0", carrierCounter); end
    testsRun++; if (bitCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_bit_count: got %0d, expected 0", bitCount); end
    testsRun++; if ({symbolStrobe, bitEnd, frameDone, resyncEvent, rxActive} !== 5'b0) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b%b%b%b%b, expected 00000", symbolStrobe, bitEnd, frameDone, resyncEvent, rxActive); end
    #20 aresetn = 1'b1;
    step();
    // Enable and a one-second edge together from IDLE only arms the receiver.
    cycleDrive(1'b0, 1'b1, 1'b1);
    cycleDrive(1'b0, 1'b0, 1'b1);
    pulses(10, 2, 1'b1);
    testsRun++; if (rxActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_edge_active: got %b, expected 0", rxActive); end
    testsRun++; if (carrierCounter !== 13'd0) begin testsFailed++; $display("[TB] FAIL idle_edge_counter: got %0d, expected 0", carrierCounter); end
  endtask

  task automatic test_alignment();
    int  firstSym = -1, firstBend = -1, bendCount = 0, edgeCyc = 0;
    bit  p, s, en;
    applyReset();
    cpPerBit = 13'd20;
    for (int t = 0; t < 16720; t++) begin
      p  = (t % 165 == 7);
      s  = (t >= 200) && (((t - 200) % 16500) < 165);
      en = (t >= 100);
      cycleDrive(p, s, en);
      if (t == 200) begin
        edgeCyc = cyc;
        testsRun++; if (rxActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL active_edge_plus1: got %b, expected 0", rxActive); end
      end
      if (t == 201) begin
        testsRun++; if (rxActive !== 1'b1) begin testsFailed++; $display("[TB] FAIL active_edge_plus2: got %b, expected 1", rxActive); end
      end
      if (symbolStrobe === 1'b1 && firstSym < 0) firstSym = cyc;
      if (bitEnd === 1'b1 && firstBend < 0) firstBend = cyc;
      if (bitEnd === 1'b1 && t >= 200 && t < 16700) bendCount++;
    end
    testsRun++; if (firstSym - edgeCyc !== 1622) begin testsFailed++; $display("[TB] FAIL first_symbol_delay: got %0d, expected 1622", firstSym - edgeCyc); end
    testsRun++; if (firstBend - edgeCyc !== 3272) begin testsFailed++; $display("[TB] FAIL first_bit_end_delay: got %0d, expected 3272", firstBend - edgeCyc); end
    testsRun++; if (bendCount !== 5) begin testsFailed++; $display("[TB] FAIL bit_ends_per_second: got %0d, expected 5", bendCount); end
    testsRun++; if (bitCount !== 16'd5) begin testsFailed++; $display("[TB] FAIL align_bit_count: got %0d, expected 5", bitCount); end
  endtask

  task automatic test_frame();
    int pulseCnt = 0;
    int guard    = 0;
    bit seen     = 1'b0;
    bit p;
    applyReset();
    cpPerBit = 13'd20;
    enterRun();
    while (!seen && guard < 1280 * 3 + 50) begin
      p = (guard % 3 == 0);
      cycleDrive(p, 1'b0, 1'b1);
      if (p) pulseCnt++;
      guard++;
      if (frameDone === 1'b1) begin
        seen = 1'b1;
        testsRun++; if (bitEnd !== 1'b1) begin testsFailed++; $display("[TB] FAIL frame_done_with_bit_end: got %b, expected 1", bitEnd); end
        testsRun++; if (bitCount !== 16'd64) begin testsFailed++; $display("[TB] FAIL frame_bit_count: got %0d, expected 64", bitCount); end
        testsRun++; if (pulseCnt !== 1280) begin testsFailed++; $display("[TB] FAIL frame_pulse_count: got %0d, expected 1280", pulseCnt); end
      end
    end
    if (!seen) begin testsRun++; testsFailed++; $display("[TB] FAIL frame_done_timeout: got none, expected frame_done within %0d cycles", guard); end
    cycleDrive(1'b0, 1'b0, 1'b1);
    testsRun++; if (rxActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_rearm_active: got %b, expected 0", rxActive); end
    pulses(12, 3, 1'b1);
    testsRun++; if (bitCount !== 16'd64) begin testsFailed++; $display("[TB] FAIL frame_hold_count: got %0d, expected 64", bitCount); end
    cycleDrive(1'b0, 1'b1, 1'b1);
    testsRun++; if (bitCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL rerun_bit_count: got %0d, expected 0", bitCount); end
    cycleDrive(1'b0, 1'b1, 1'b1);
    testsRun++; if (rxActive !== 1'b1) begin testsFailed++; $display("[TB] FAIL rerun_active: got %b, expected 1", rxActive); end
    pulses(10, 3, 1'b1);
    testsRun++; if (carrierCounter !== 13'd10) begin testsFailed++; $display("[TB] FAIL rerun_counter: got %0d, expected 10", carrierCounter); end
  endtask

  task automatic test_clamp();
    applyReset();
    cpPerBit = 13'd1;
    enterRun();
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) cpPerBit = 13'd20;
      cycleDrive(1'b1, 1'b0, 1'b1);
      testsRun++; if (carrierCounter !== 13'(i % 2)) begin testsFailed++; $display("[TB] FAIL clamp_counter pulse %0d: got %0d, expected %0d", i, carrierCounter, i % 2); end
      testsRun++; if (symbolStrobe !== 1'(i % 2)) begin testsFailed++; $display("[TB] FAIL clamp_symbol pulse %0d: got %b, expected %0d", i, symbolStrobe, i % 2); end
      cycleDrive(1'b0, 1'b0, 1'b1);
    end
    testsRun++; if (bitCount !== 16'd4) begin testsFailed++; $display("[TB] FAIL clamp_bit_count: got %0d, expected 4", bitCount); end
  endtask

  task automatic test_abort();
    applyReset();
    cpPerBit = 13'd20;
    enterRun();
    pulses(67, 2, 1'b1);
    testsRun++; if (carrierCounter !== 13'd7 || bitCount !== 16'd3) begin testsFailed++; $display("[TB] FAIL abort_setup: got counter %0d bits %0d, expected 7 and 3", carrierCounter, bitCount); end
    cycleDrive(1'b1, 1'b0, 1'b0);
    testsRun++; if (carrierCounter !== 13'd7) begin testsFailed++; $display("[TB] FAIL abort_counter_hold: got %0d, expected 7", carrierCounter); end
    cycleDrive(1'b0, 1'b0, 1'b0);
    testsRun++; if (rxActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_active: got %b, expected 0", rxActive); end
    pulses(10, 2, 1'b0);
    cycleDrive(1'b0, 1'b1, 1'b0);
    pulses(10, 2, 1'b0);
    cycleDrive(1'b0, 1'b0, 1'b1);
    pulses(10, 2, 1'b1);
    testsRun++; if (carrierCounter !== 13'd7 || bitCount !== 16'd3) begin testsFailed++; $display("[TB] FAIL abort_rearm_hold: got counter %0d bits %0d, expected 7 and 3", carrierCounter, bitCount); end
    testsRun++; if (rxActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_rearm_active: got %b, expected 0", rxActive); end
    cycleDrive(1'b0, 1'b1, 1'b1);
    cycleDrive(1'b0, 1'b0, 1'b1);
    testsRun++; if (carrierCounter !== 13'd0 || bitCount !== 16'd0 || rxActive !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_restart: got counter %0d bits %0d active %b, expected 0 0 1", carrierCounter, bitCount, rxActive); end
    pulses(10, 2, 1'b1);
  endtask

  task automatic test_reset_midrun();
    applyReset();
    cpPerBit = 13'd20;
    enterRun();
    pulses(25, 2, 1'b1);
    testsRun++; if (carrierCounter !== 13'd5 || bitCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL midrun_setup: got counter %0d bits %0d, expected 5 and 1", carrierCounter, bitCount); end
    #20 aresetn = 1'b0;
    #1;
    testsRun++; if (carrierCounter !== 13'd0 || bitCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL midrun_reset_counts: got counter %0d bits %0d, expected 0 and 0", carrierCounter, bitCount); end
    testsRun++; if ({symbolStrobe, bitEnd, frameDone, resyncEvent, rxActive} !== 5'b0) begin testsFailed++; $display("[TB] FAIL midrun_reset_flags: got %b%b%b%b%b, expected 00000", symbolStrobe, bitEnd, frameDone, resyncEvent, rxActive); end
    carrierPulse = 1'b0; oneSec = 1'b0; rxEnable = 1'b0;
    mState = M_IDLE; prevSec = 1'b0; mPulses = 0; mBits = 0;
    expQ.delete();
    step();
    #20 aresetn = 1'b1;
    step();
    pulses(12, 2, 1'b1);
    testsRun++; if (rxActive !== 1'b0 || carrierCounter !== 13'd0) begin testsFailed++; $display("[TB] FAIL midrun_post_reset: got active %b counter %0d, expected 0 and 0", rxActive, carrierCounter); end
    cycleDrive(1'b0, 1'b1, 1'b1);
    pulses(10, 2, 1'b1);
    testsRun++; if (carrierCounter !== 13'd10) begin testsFailed++; $display("[TB] FAIL midrun_resume_counter: got %0d, expected 10", carrierCounter); end
  endtask

  task automatic test_resync();
    int n     = 0;
    bit found = 1'b0;
    applyReset();
    cpPerBit = 13'd20;
    enterRun();
    pulses(32, 5, 1'b1);
    testsRun++; if (carrierCounter !== 13'd12 || bitCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL resync_setup: got counter %0d bits %0d, expected 12 and 1", carrierCounter, bitCount); end
    cycleDrive(1'b1, 1'b1, 1'b1);
    testsRun++; if (resyncEvent !== RESYNC) begin testsFailed++; $display("[TB] FAIL resync_event: got %b, expected %b", resyncEvent, RESYNC); end
    testsRun++; if (carrierCounter !== (RESYNC ? 13'd0 : 13'd13)) begin testsFailed++; $display("[TB] FAIL resync_counter: got %0d, expected %0d", carrierCounter, RESYNC ? 0 : 13); end
    testsRun++; if (bitCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL resync_bit_count: got %0d, expected 1", bitCount); end
    repeat (4) cycleDrive(1'b0, 1'b0, 1'b1);
    while (!found && n < 40) begin
      cycleDrive(1'b1, 1'b0, 1'b1);
      n++;
      if (bitEnd === 1'b1) found = 1'b1;
      repeat (4) cycleDrive(1'b0, 1'b0, 1'b1);
    end
    testsRun++; if (!found || n !== (RESYNC ? 20 : 7)) begin testsFailed++; $display("[TB] FAIL resync_next_bit_end: got %0d pulses (found=%b), expected %0d", n, found, RESYNC ? 20 : 7); end
    cycleDrive(1'b0, 1'b0, 1'b1);
    testsRun++; if (expQ.size() !== 0) begin testsFailed++; $display("[TB] FAIL scoreboard_drained: got %0d pending, expected 0", expQ.size()); end
  endtask

  initial begin
    aresetn      = 1'b0;
    carrierPulse = 1'b0;
    oneSec       = 1'b0;
    rxEnable     = 1'b0;
    cpPerBit     = 13'd20;
    test_reset();
    test_alignment();
    test_frame();
    test_clamp();
    test_abort();
    test_reset_midrun();
    test_resync();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
